// File: rtl/id_ex_fwd_pkg.sv
// Shared widths and constant words for the ID/EX forwarding stage.
// The default parameter values and the zero-word/zero-register constants live here.
package id_ex_fwd_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int NUM_SRC_DEF = 2;
    localparam int NUM_FWD_DEF = 2;
    localparam int CTRL_W_DEF  = 128;
    localparam int CNT_W_DEF   = 16;

    localparam logic [DATA_W_DEF-1:0] ZeroWord   = '0;
    localparam logic [ADDR_W_DEF-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/id_ex_fwd_fwd_sel.sv
// Operand resolver for one source: immediate, youngest matching forward port, or regfile.
// Also flags when the selected forward port has not produced its value yet.
module fwd_sel
    import id_ex_fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic                      rd_en_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_pending_i,
    output logic [DATA_W-1:0]         data_o,
    output logic                      hazard_o
);

    logic hit;

    // Port 0 is the youngest producer, so the first hit wins and later ports are ignored.
    always_comb begin
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        hit      = 1'b0;
        if (!rd_en_i) begin
            data_o = imm_i;
        end else if (rd_addr_i != ADDR_W'(NOPRegAddr)) begin
            for (int j = 0; j < NUM_FWD; j++) begin
                if (!hit && fwd_we_i[j] && (fwd_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                    hit      = 1'b1;
                    data_o   = fwd_data_i[j*DATA_W +: DATA_W];
                    hazard_o = fwd_pending_i[j];
                end
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush.
// Ready/valid handshake on both sides; stall_cnt counts cycles spent in a load-use hazard.
module id_ex_fwd
    import id_ex_fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [NUM_SRC-1:0]        in_rd_en,
    input  logic [NUM_SRC*ADDR_W-1:0] in_rd_addr,
    input  logic [NUM_SRC*DATA_W-1:0] rf_data,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_SRC*DATA_W-1:0] out_src,
    output logic                      hazard,
    output logic [CNT_W-1:0]          stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [NUM_SRC*DATA_W-1:0] src_res;
    logic [NUM_SRC-1:0]        src_haz;
    logic                      hazard_raw;
    logic                      accept;

    logic                      out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]         out_ctrl_q,  out_ctrl_d;
    logic [NUM_SRC*DATA_W-1:0] out_src_q,   out_src_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_sel #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_FWD (NUM_FWD)
        ) u_fwd_sel (
            .rd_en_i       (in_rd_en[g]),
            .rd_addr_i     (in_rd_addr[g*ADDR_W +: ADDR_W]),
            .rf_data_i     (rf_data[g*DATA_W +: DATA_W]),
            .imm_i         (in_imm),
            .fwd_we_i      (fwd_we),
            .fwd_addr_i    (fwd_addr),
            .fwd_data_i    (fwd_data),
            .fwd_pending_i (fwd_pending),
            .data_o        (src_res[g*DATA_W +: DATA_W]),
            .hazard_o      (src_haz[g])
        );
    end

    assign hazard_raw = |src_haz;
    assign hazard     = in_valid & hazard_raw;
    assign in_ready   = (!out_valid_q || out_ready) && !hazard_raw && !flush;
    assign accept     = in_valid & in_ready;

    // Flush beats accept, and a consumed entry with nothing behind it becomes a NOP bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ctrl_d  = out_ctrl_q;
        out_src_d   = out_src_q;
        stall_cnt_d = hazard ? sat_inc(stall_cnt_q) : stall_cnt_q;
        if (flush || (!accept && out_valid_q && out_ready)) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = '0;
            out_src_d   = {NUM_SRC{DATA_W'(ZeroWord)}};
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl;
            out_src_d   = src_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_src_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_src_q   <= out_src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_src   = out_src_q;
    assign stall_cnt = stall_cnt_q;

endmodule
